// File: rtl/alu_result_misr.sv
// alu_result_misr: folds a window of valid ALU results into a MISR signature and compares it to a golden value.
// Optional shadow-ALU lockstep checker enabled by defining ALU_MISR_LOCKSTEP_EN.
module alu_result_misr #(
    parameter int unsigned          DATA_W = 64,
    parameter int unsigned          WINDOW = 1024,
    parameter logic [DATA_W-1:0]    POLY   = 64'h0000_0000_0000_001B,
    parameter logic [DATA_W-1:0]    SEED   = 64'h0,
    localparam int unsigned         CW     = $clog2(WINDOW + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] golden_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic              cmp_i,
    input  logic              shadow_valid_i,
    input  logic [DATA_W-1:0] shadow_result_i,
    input  logic              shadow_cmp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic [DATA_W-1:0] signature_o,
    output logic [CW-1:0]     count_o,
    output logic              lockstep_err_o,
    output logic [CW-1:0]     first_err_idx_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPACT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    logic [1:0]        state;
    logic [DATA_W-1:0] sig;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] sig_n;
    logic [CW-1:0]     count;
    logic              pass_q;
    logic              fail_q;
    logic              absorb;
    logic              last_smp;

    assign d        = result_i ^ {cmp_i, {(DATA_W-1){1'b0}}};
    assign sig_n    = {sig[DATA_W-2:0], 1'b0}
                    ^ (sig[DATA_W-1] ? POLY : '0)
                    ^ d;
    assign absorb   = (state == S_COMPACT) && valid_i;
    assign last_smp = (count == LAST);

    // Window FSM, signature shift register, sample counter and verdict.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= S_IDLE;
            sig    <= SEED;
            count  <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (start_i) begin
            state  <= S_COMPACT;
            sig    <= SEED;
            count  <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (absorb) begin
            sig   <= sig_n;
            count <= count + 1'b1;
            if (last_smp) begin
                state  <= S_DONE;
                pass_q <= (sig_n == golden_i);
                fail_q <= (sig_n != golden_i);
            end
        end
    end

    assign busy_o      = (state == S_COMPACT);
    assign done_o      = (state == S_DONE);
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign signature_o = sig;
    assign count_o     = count;

`ifdef ALU_MISR_LOCKSTEP_EN
    logic          ls_err;
    logic [CW-1:0] ls_idx;
    logic          mismatch;

    assign mismatch = (valid_i != shadow_valid_i)
                    || (valid_i && shadow_valid_i
                        && ({result_i, cmp_i} != {shadow_result_i, shadow_cmp_i}));

    // Sticky capture of the first shadow-ALU divergence within a window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ls_err <= 1'b0;
            ls_idx <= '0;
        end else if (start_i) begin
            ls_err <= 1'b0;
            ls_idx <= '0;
        end else if (state == S_COMPACT && mismatch && !ls_err) begin
            ls_err <= 1'b1;
            ls_idx <= count;
        end
    end

    assign lockstep_err_o  = ls_err;
    assign first_err_idx_o = ls_idx;
`else
    logic unused_shadow;
    assign unused_shadow   = ^{shadow_valid_i, shadow_result_i, shadow_cmp_i};
    assign lockstep_err_o  = 1'b0;
    assign first_err_idx_o = '0;
`endif

endmodule

// File: tb/tb_alu_result_misr.sv
// tb_alu_result_misr: randomized self-checking bench for alu_result_misr.
// Main DUT uses WINDOW=4; a second instance covers WINDOW=1.
module tb_alu_result_misr;

    localparam logic [63:0] POLY = 64'h1B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] golden = '0;
    logic        valid = 1'b0;
    logic [63:0] result = '0;
    logic        cmp = 1'b0;
    logic        s_valid = 1'b0;
    logic [63:0] s_result = '0;
    logic        s_cmp = 1'b0;

    logic        busy, done, pass, fail, lerr;
    logic [63:0] sig;
    logic [2:0]  cnt, fidx;
    logic        busy1, done1, pass1, fail1, lerr1;
    logic [63:0] sig1;
    logic [0:0]  cnt1, fidx1;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_sig;
    int          m_cnt;

    always #5 clk = ~clk;

    alu_result_misr #(.DATA_W(64), .WINDOW(4), .POLY(POLY), .SEED(64'h0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .golden_i(golden),
        .valid_i(valid), .result_i(result), .cmp_i(cmp),
        .shadow_valid_i(s_valid), .shadow_result_i(s_result), .shadow_cmp_i(s_cmp),
        .busy_o(busy), .done_o(done), .pass_o(pass), .fail_o(fail),
        .signature_o(sig), .count_o(cnt),
        .lockstep_err_o(lerr), .first_err_idx_o(fidx)
    );

    alu_result_misr #(.DATA_W(64), .WINDOW(1), .POLY(POLY), .SEED(64'h0)) u_w1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .golden_i(golden),
        .valid_i(valid), .result_i(result), .cmp_i(cmp),
        .shadow_valid_i(s_valid), .shadow_result_i(s_result), .shadow_cmp_i(s_cmp),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .fail_o(fail1),
        .signature_o(sig1), .count_o(cnt1),
        .lockstep_err_o(lerr1), .first_err_idx_o(fidx1)
    );

    // Signature times x modulo the feedback polynomial, plus the sample.
    function automatic logic [63:0] mstep(logic [63:0] s, logic [63:0] r, logic c);
        logic [64:0] t;
        t = {s, 1'b0};
        if (t[64]) t = t ^ {1'b1, POLY};
        return t[63:0] ^ r ^ (c ? 64'h8000_0000_0000_0000 : 64'h0);
    endfunction

    task automatic smp(input logic v, input logic [63:0] r, input logic c);
        valid = v; result = r; cmp = c;
        s_valid = v; s_result = r; s_cmp = c;
        @(posedge clk); #1;
        valid = 1'b0; s_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        smp($urandom_range(0, 1) == 1, {$urandom, $urandom}, 1'b0);
        start = 1'b0;
        m_sig = '0; m_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = $urandom_range(0, 1) == 1;
            smp($urandom_range(0, 1) == 1, {$urandom, $urandom}, 1'(($urandom)));
            checks++;
            if ({busy, done, pass, fail, lerr, sig, cnt, fidx} !== '0) begin
                errors++;
                $display("FAIL reset_outs got sig=%h cnt=%0d b=%b d=%b p=%b f=%b e=%b", sig, cnt, busy, done, pass, fail, lerr);
            end
        end
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) smp(1'b1, {$urandom, $urandom}, 1'b0);
        checks++;
        if (cnt !== 3'd0 || busy !== 1'b0 || sig !== 64'h0) begin
            errors++;
            $display("FAIL idle_ignore got cnt=%0d busy=%b sig=%h exp 0 0 0", cnt, busy, sig);
        end
    endtask

    task automatic test_basic();
        logic [63:0] exp_seq [4];
        exp_seq[0] = 64'h1; exp_seq[1] = 64'h3; exp_seq[2] = 64'h7; exp_seq[3] = 64'hF;
        for (int g = 0; g < 2; g++) begin
            do_start();
            checks++;
            if (busy !== 1'b1 || cnt !== 3'd0 || sig !== 64'h0) begin
                errors++;
                $display("FAIL basic_start got busy=%b cnt=%0d sig=%h", busy, cnt, sig);
            end
            golden = (g == 0) ? 64'hF : 64'hE;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_done got %b exp 0", done);
                end
                smp(1'b1, 64'h1, 1'b0);
                checks++;
                if (sig !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL basic_sig%0d got %h exp %h", i, sig, exp_seq[i]);
                end
            end
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || pass !== (g == 0) || fail !== (g == 1)) begin
                errors++;
                $display("FAIL basic_verdict%0d got d=%b b=%b p=%b f=%b", g, done, busy, pass, fail);
            end
        end
    endtask

    task automatic test_feedback();
        do_start();
        smp(1'b1, 64'h0, 1'b1);
        checks++;
        if (sig !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("FAIL fold_cmp got %h exp 8000000000000000", sig);
        end
        smp(1'b1, 64'h0, 1'b0);
        checks++;
        if (sig !== 64'h1B) begin
            errors++;
            $display("FAIL feedback got %h exp 1b", sig);
        end
    endtask

    task automatic test_gaps_abort();
        logic pat [4];
        logic [63:0] r;
        logic ep;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) smp(pat[i], {$urandom, $urandom}, 1'b0);
        checks++;
        if (cnt !== 3'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_count got cnt=%0d busy=%b exp 2 1", cnt, busy);
        end
        do_start();
        checks++;
        if (cnt !== 3'd0 || busy !== 1'b1 || sig !== 64'h0) begin
            errors++;
            $display("FAIL abort got cnt=%0d busy=%b sig=%h exp 0 1 0", cnt, busy, sig);
        end
        ep = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = {$urandom, $urandom};
            m_sig = mstep(m_sig, r, 1'b0);
            golden = m_sig;
            smp(1'b1, r, 1'b0);
        end
        ep = 1'b1;
        checks++;
        if (done !== 1'b1 || sig !== m_sig || pass !== ep || fail !== 1'b0) begin
            errors++;
            $display("FAIL restart_window got d=%b sig=%h p=%b exp sig=%h", done, sig, pass, m_sig);
        end
    endtask

    task automatic test_ignore_done();
        logic [63:0] s0;
        logic [2:0]  c0;
        logic        p0;
        s0 = sig; c0 = cnt; p0 = pass;
        for (int i = 0; i < 10; i++) smp(1'b1, {$urandom, $urandom}, 1'(($urandom)));
        checks++;
        if (sig !== s0 || cnt !== c0 || pass !== p0 || done !== 1'b1 || cnt !== 3'd4) begin
            errors++;
            $display("FAIL ignore_done got sig=%h cnt=%0d p=%b d=%b exp sig=%h cnt=4", sig, cnt, pass, done, s0);
        end
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic        c, v, ep, en;
        int          guard;
        for (int w = 0; w < 6; w++) begin
            do_start();
            guard = 0; ep = 1'b0;
            while (m_cnt < 4 && guard < 40) begin
                v = $urandom_range(0, 2) != 0;
                r = {$urandom, $urandom};
                c = 1'(($urandom));
                en = mstep(m_sig, r, c) == mstep(m_sig, r, c);
                golden = ($urandom_range(0, 1) == 1) ? mstep(m_sig, r, c) : {$urandom, $urandom};
                if (v) begin
                    m_sig = mstep(m_sig, r, c);
                    m_cnt++;
                    if (m_cnt == 4) ep = (golden == m_sig) && en;
                end
                smp(v, r, c);
                guard++;
                checks++;
                if (sig !== m_sig || cnt !== 3'(m_cnt)) begin
                    errors++;
                    $display("FAIL rand_step w%0d got sig=%h cnt=%0d exp sig=%h cnt=%0d", w, sig, cnt, m_sig, m_cnt);
                end
            end
            checks++;
            if (done !== 1'b1 || pass !== ep || fail !== !ep) begin
                errors++;
                $display("FAIL rand_verdict w%0d got d=%b p=%b f=%b exp p=%b", w, done, pass, fail, ep);
            end
        end
    endtask

    task automatic test_lockstep();
        logic [63:0] r;
        logic        exp_e;
`ifdef ALU_MISR_LOCKSTEP_EN
        exp_e = 1'b1;
`else
        exp_e = 1'b0;
`endif
        do_start();
        for (int i = 0; i < 4; i++) begin
            r = {$urandom, $urandom};
            valid = 1'b1; result = r; cmp = 1'b0;
            s_valid = 1'b1; s_result = (i == 2) ? (r ^ 64'h1) : r; s_cmp = 1'b0;
            m_sig = mstep(m_sig, r, 1'b0);
            golden = m_sig;
            @(posedge clk); #1;
            valid = 1'b0; s_valid = 1'b0;
            checks++;
            if (lerr !== ((i >= 2) ? exp_e : 1'b0) || fidx !== ((i >= 2 && exp_e) ? 3'd2 : 3'd0)) begin
                errors++;
                $display("FAIL lockstep_s%0d got e=%b idx=%0d", i, lerr, fidx);
            end
        end
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || sig !== m_sig || lerr !== exp_e) begin
            errors++;
            $display("FAIL lockstep_done got d=%b p=%b e=%b sig=%h exp %h", done, pass, lerr, sig, m_sig);
        end
        do_start();
        checks++;
        if (lerr !== 1'b0 || fidx !== 3'd0) begin
            errors++;
            $display("FAIL lockstep_clear got e=%b idx=%0d exp 0 0", lerr, fidx);
        end
    endtask

    task automatic test_window1();
        logic [63:0] r;
        do_start();
        r = {$urandom, $urandom};
        golden = r ^ 64'h8000_0000_0000_0000;
        smp(1'b1, r, 1'b1);
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || cnt1 !== 1'b1 || sig1 !== golden || pass1 !== 1'b1 || fail1 !== 1'b0) begin
            errors++;
            $display("FAIL window1 got d=%b cnt=%0d sig=%h p=%b exp sig=%h", done1, cnt1, sig1, pass1, golden);
        end
    endtask

    task automatic test_midreset();
        do_start();
        smp(1'b1, {$urandom, $urandom}, 1'b1);
        smp(1'b1, {$urandom, $urandom}, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sig !== 64'h0 || cnt !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset got sig=%h cnt=%0d busy=%b", sig, cnt, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_feedback();
        test_gaps_abort();
        test_ignore_done();
        test_random();
        test_lockstep();
        test_window1();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
